// File: rtl/plane_sample_scheduler_pkg.sv
// Shared fixed-point types and scheduler constants for the RANSAC plane pipeline.
package ransac_fixed;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } point_t;

    typedef struct packed {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [15:0] c;
        logic signed [15:0] d;
    } plane_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PICK, ST_READ, ST_ISSUE, ST_DRAIN, ST_FINISH
    } state_e;

    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] SEED_ZERO_SUB = 32'h0000_0001;

    // Right-shifting Galois step; the all-zero state is never entered.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/plane_sample_scheduler_if.sv
// Point-memory, find_plane and result-stream channels of the sample scheduler.
interface plane_sample_scheduler_if #(parameter int index_bits = 10);
    import ransac_fixed::*;

    logic                  mem_rd;
    logic [index_bits-1:0] mem_addr;
    point_t                mem_data;

    point_t                fp_a, fp_b, fp_c;
    logic                  fp_valid, fp_ready;
    plane_t                fp_plane;
    logic                  fp_plane_valid;

    plane_t                plane_out;
    logic                  plane_out_valid, plane_out_ready;
    logic [15:0]           plane_seq;

    modport master (
        output mem_rd, mem_addr, input mem_data,
        output fp_a, fp_b, fp_c, fp_valid, input fp_ready,
        input  fp_plane, fp_plane_valid,
        output plane_out, plane_out_valid, plane_seq, input plane_out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, output mem_data,
        input  fp_a, fp_b, fp_c, fp_valid, output fp_ready,
        output fp_plane, fp_plane_valid,
        input  plane_out, plane_out_valid, plane_seq, output plane_out_ready
    );
endinterface

// File: rtl/plane_sample_scheduler_fifo.sv
// Result buffer for find_plane outputs; power-of-2 depth, head is zero when empty.
module plane_fifo
    import ransac_fixed::*;
#(
    parameter  int depth = 4,
    localparam int AW    = $clog2(depth),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  plane_t        wr_data,
    input  logic          pop,
    output plane_t        rd_data,
    output logic [CW-1:0] count
);
    plane_t          mem [depth];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_pop;

    assign do_pop  = pop && (count != '0);
    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/plane_sample_scheduler.sv
// Draws three distinct random point indices per sample, fetches the points and
// feeds find_plane, holding outstanding requests within the result buffer depth.
module plane_sample_scheduler
    import ransac_fixed::*;
#(
    parameter int index_bits = 10,
    parameter int fifo_depth = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           iterations,
    input  logic [index_bits:0]   num_points,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    plane_sample_scheduler_if.master bus
);
    localparam int CW = $clog2(fifo_depth) + 1;

    state_e                     state;
    logic [31:0]                lfsr;
    logic [15:0]                iter_q, issued, seq;
    logic [index_bits:0]        npts_q;
    logic                       few_pts;
    logic [2:0][index_bits-1:0] idx;
    logic [1:0]                 acc_cnt, rd_cnt, rd_sel;
    logic                       rd_vld;
    logic [CW-1:0]              outstanding, fifo_cnt;
    point_t                     a_q, b_q, c_q;
    logic                       fpv_q;
    logic [index_bits-1:0]      cand;
    logic                       cand_ok, xfer, pop, push, short_run;

    assign cand    = lfsr[index_bits-1:0];
    // Later picks must differ from every index already taken in this sample.
    assign cand_ok = ({1'b0, cand} < npts_q)
                  && !((acc_cnt != 2'd0) && (cand == idx[0]))
                  && !((acc_cnt == 2'd2) && (cand == idx[1]));
    assign xfer      = fpv_q && bus.fp_ready;
    assign pop       = bus.plane_out_valid && bus.plane_out_ready;
    assign push      = bus.fp_plane_valid && (state != ST_IDLE);
    assign short_run = (iterations == 16'd0) || (num_points < (index_bits+1)'(3));

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_FINISH);
    assign error = done && few_pts;

    assign bus.mem_rd          = (state == ST_READ);
    assign bus.mem_addr        = (state == ST_READ) ? idx[rd_cnt] : '0;
    assign bus.fp_a            = a_q;
    assign bus.fp_b            = b_q;
    assign bus.fp_c            = c_q;
    assign bus.fp_valid        = fpv_q;
    assign bus.plane_out_valid = (fifo_cnt != '0);
    assign bus.plane_seq       = seq;

    plane_fifo #(.depth(fifo_depth)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (bus.fp_plane),
        .pop     (pop),
        .rd_data (bus.plane_out),
        .count   (fifo_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            lfsr        <= 32'd1;
            iter_q      <= '0;
            issued      <= '0;
            seq         <= '0;
            npts_q      <= '0;
            few_pts     <= 1'b0;
            idx         <= '0;
            acc_cnt     <= '0;
            rd_cnt      <= '0;
            rd_sel      <= '0;
            rd_vld      <= 1'b0;
            outstanding <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            fpv_q       <= 1'b0;
        end else begin
            rd_vld <= 1'b0;
            // Memory data lands one cycle after each read; the third word arms the request.
            if (rd_vld) begin
                case (rd_sel)
                    2'd0:    a_q <= bus.mem_data;
                    2'd1:    b_q <= bus.mem_data;
                    default: begin
                        c_q   <= bus.mem_data;
                        fpv_q <= 1'b1;
                    end
                endcase
            end
            if (xfer) begin
                fpv_q  <= 1'b0;
                issued <= issued + 16'd1;
            end
            outstanding <= outstanding + CW'(xfer) - CW'(pop);
            if (pop) seq <= seq + 16'd1;

            case (state)
                ST_IDLE: if (start) begin
                    iter_q  <= iterations;
                    npts_q  <= num_points;
                    few_pts <= (num_points < (index_bits+1)'(3));
                    lfsr    <= (seed == 32'd0) ? SEED_ZERO_SUB : seed;
                    issued  <= '0;
                    acc_cnt <= '0;
                    seq     <= '0;
                    state   <= short_run ? ST_FINISH : ST_PICK;
                end
                ST_PICK: begin
                    lfsr <= lfsr_next(lfsr);
                    if (cand_ok) begin
                        idx[acc_cnt] <= cand;
                        if (acc_cnt == 2'd2) begin
                            acc_cnt <= '0;
                            rd_cnt  <= '0;
                            state   <= ST_READ;
                        end else begin
                            acc_cnt <= acc_cnt + 2'd1;
                        end
                    end
                end
                ST_READ: begin
                    rd_vld <= 1'b1;
                    rd_sel <= rd_cnt;
                    if (rd_cnt == 2'd2) state <= ST_ISSUE;
                    else                rd_cnt <= rd_cnt + 2'd1;
                end
                ST_ISSUE: begin
                    // After a transfer, wait here for a free credit before picking again.
                    if (xfer) begin
                        if (issued + 16'd1 == iter_q) state <= ST_DRAIN;
                    end else if (!fpv_q && !rd_vld && (outstanding < CW'(fifo_depth))) begin
                        state <= ST_PICK;
                    end
                end
                ST_DRAIN: if (outstanding == '0 && fifo_cnt == '0) state <= ST_FINISH;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plane_sample_scheduler.sv
// Directed bench for plane_sample_scheduler with point memory and find_plane models.
`timescale 1ns/1ps
module tb_plane_sample_scheduler;
    import ransac_fixed::*;
    localparam int IB = 10;

    logic          clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [15:0]   iterations = '0;
    logic [IB:0]   num_points = '0;
    logic [31:0]   seed = '0;
    logic          busy, done, error;
    int            n_chk = 0, n_fail = 0;

    plane_sample_scheduler_if #(.index_bits(IB)) bus ();

    plane_sample_scheduler #(.index_bits(IB), .fifo_depth(4)) dut (
        .clock(clock), .reset(reset), .start(start), .iterations(iterations),
        .num_points(num_points), .seed(seed), .busy(busy), .done(done),
        .error(error), .bus(bus)
    );

    always #5 clock = ~clock;

    // point memory: one-cycle read latency
    function automatic point_t pt(input logic [IB-1:0] a);
        point_t p;
        p.x = 16'(a);
        p.y = 16'(a) + 16'd100;
        p.z = 16'(a) + 16'd200;
        return p;
    endfunction
    always @(posedge clock) if (bus.mem_rd) bus.mem_data <= pt(bus.mem_addr);

    // find_plane: fixed 2-cycle latency, result tagged with global transfer number
    logic [1:0]  fpv_pipe = '0;
    plane_t      pl_pipe [2];
    logic [15:0] xfer_tag = '0;
    always @(posedge clock) begin
        fpv_pipe   <= {fpv_pipe[0], bus.fp_valid && bus.fp_ready};
        pl_pipe[0] <= '{a: bus.fp_a.x, b: bus.fp_b.x, c: bus.fp_c.x, d: xfer_tag};
        pl_pipe[1] <= pl_pipe[0];
        if (bus.fp_valid && bus.fp_ready) xfer_tag <= xfer_tag + 16'd1;
    end
    assign bus.fp_plane_valid = fpv_pipe[1];
    assign bus.fp_plane       = pl_pipe[1];

    // event recorder
    int            n_xfer = 0, n_done = 0, n_fpv = 0;
    logic [IB-1:0] addr_q [$];
    logic [15:0]   seq_q [$], tag_q [$];
    logic          err_q [$];
    always @(negedge clock) begin
        if (bus.mem_rd) addr_q.push_back(bus.mem_addr);
        if (bus.fp_valid) n_fpv <= n_fpv + 1;
        if (bus.fp_valid && bus.fp_ready) n_xfer <= n_xfer + 1;
        if (bus.plane_out_valid && bus.plane_out_ready) begin
            seq_q.push_back(bus.plane_seq);
            tag_q.push_back(16'(bus.plane_out.d));
        end
        if (done) begin
            n_done <= n_done + 1;
            err_q.push_back(error);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic go(input logic [31:0] s, input logic [IB:0] np, input logic [15:0] it);
        seed = s; num_points = np; iterations = it; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin tick(1); k++; end
        chk({tag, "_done"}, 32'(done), 1);
        tick(1);
    endtask

    function automatic logic [31:0] sw_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic sw_pick(inout logic [31:0] s, input int np, output int a, output int b, output int c);
        int got [3];
        int n = 0;
        int cand;
        while (n < 3) begin
            cand = int'(s[IB-1:0]);
            if (cand < np && (n < 1 || cand != got[0]) && (n < 2 || cand != got[1])) begin
                got[n] = cand;
                n++;
            end
            s = sw_step(s);
        end
        a = got[0]; b = got[1]; c = got[2];
    endtask

    int          base_a, base_p, base_x, base_d, base_f, k, ea, eb, ec, a, b, c;
    logic [31:0] s;
    logic        stable;
    point_t      ha, hb, hc;

    initial begin
        bus.fp_ready = 1'b1;
        bus.plane_out_ready = 1'b1;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_fp_valid", 32'(bus.fp_valid), 0);
        chk("rst_fp_a", 32'(bus.fp_a), 0);
        chk("rst_out_valid", 32'(bus.plane_out_valid), 0);
        chk("rst_seq", 32'(bus.plane_seq), 0);
        reset = 1'b1;
        tick(2);

        // seed 1: LFSR low bits 1, 3, 2 on the first three steps
        base_a = addr_q.size(); base_p = seq_q.size(); base_x = n_xfer; base_d = err_q.size();
        go(32'd1, 11'd1024, 16'd1);
        chk("t2_busy", 32'(busy), 1);
        k = 1;
        while (!bus.fp_valid && k < 40) begin tick(1); k++; end
        chk("t2_latency", k, 8);
        chk("t2_idx_a", 32'(addr_q[base_a]), 1);
        chk("t2_idx_b", 32'(addr_q[base_a+1]), 3);
        chk("t2_idx_c", 32'(addr_q[base_a+2]), 2);
        chk("t2_fp_a", 32'(bus.fp_a.x), 1);
        chk("t2_fp_b", 32'(bus.fp_b.x), 3);
        chk("t2_fp_c_z", 32'(bus.fp_c.z), 202);
        wait_done("t2", 50);
        chk("t2_planes", seq_q.size() - base_p, 1);
        chk("t2_seq0", 32'(seq_q[base_p]), 0);
        chk("t2_tag0", 32'(tag_q[base_p]), 32'(base_x));
        chk("t2_err", 32'(err_q[base_d]), 0);
        chk("t2_idle", 32'(busy), 0);

        // three points: every sample a permutation of {0,1,2}
        base_a = addr_q.size(); base_p = seq_q.size(); base_x = n_xfer; base_d = err_q.size();
        go(32'h0000_ACE1, 11'd3, 16'd5);
        wait_done("t3", 40000);
        chk("t3_reads", addr_q.size() - base_a, 15);
        s = 32'h0000_ACE1;
        for (int i = 0; i < 5; i++) begin
            sw_pick(s, 3, ea, eb, ec);
            a = int'(addr_q[base_a+3*i]); b = int'(addr_q[base_a+3*i+1]); c = int'(addr_q[base_a+3*i+2]);
            chk($sformatf("t3_perm%0d", i), 32'(a < 3 && b < 3 && c < 3 && a != b && b != c && a != c), 1);
            chk($sformatf("t3_model%0d", i), (a << 8) | (b << 4) | c, (ea << 8) | (eb << 4) | ec);
        end
        chk("t3_planes", seq_q.size() - base_p, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_seq%0d", i), 32'(seq_q[base_p+i]), i);
            chk($sformatf("t3_tag%0d", i), 32'(tag_q[base_p+i]), 32'(base_x + i));
        end
        chk("t3_err", 32'(err_q[base_d]), 0);

        // too few points: immediate done with error, no traffic
        base_a = addr_q.size(); base_f = n_fpv; base_d = err_q.size();
        go(32'h1234, 11'd2, 16'd5);
        chk("t4_done", 32'(done), 1);
        chk("t4_error", 32'(error), 1);
        tick(1);
        chk("t4_busy_low", 32'(busy), 0);
        chk("t4_done_low", 32'(done), 0);
        chk("t4_no_rd", addr_q.size() - base_a, 0);
        chk("t4_no_fpv", n_fpv - base_f, 0);
        chk("t4_one_done", err_q.size() - base_d, 1);

        // blocked result stream: credits cap outstanding requests at 4
        bus.plane_out_ready = 1'b0;
        base_p = seq_q.size(); base_x = n_xfer; base_d = err_q.size();
        go(32'h0000_5EED, 11'd1024, 16'd8);
        tick(80);
        chk("t5_stall_xfers", n_xfer - base_x, 4);
        chk("t5_out_valid", 32'(bus.plane_out_valid), 1);
        chk("t5_busy", 32'(busy), 1);
        bus.plane_out_ready = 1'b1;
        wait_done("t5", 400);
        tick(5);
        chk("t5_planes", seq_q.size() - base_p, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_seq%0d", i), 32'(seq_q[base_p+i]), i);
            chk($sformatf("t5_tag%0d", i), 32'(tag_q[base_p+i]), 32'(base_x + i));
        end
        chk("t5_single_done", err_q.size() - base_d, 1);

        // find_plane not ready: request held stable for 20 cycles
        bus.fp_ready = 1'b0;
        base_x = n_xfer;
        go(32'h0000_BEEF, 11'd1024, 16'd1);
        k = 0;
        while (!bus.fp_valid && k < 50) begin tick(1); k++; end
        chk("t6_fpv_seen", 32'(bus.fp_valid), 1);
        ha = bus.fp_a; hb = bus.fp_b; hc = bus.fp_c;
        stable = 1'b1;
        repeat (20) begin
            tick(1);
            if (!bus.fp_valid || bus.fp_a != ha || bus.fp_b != hb || bus.fp_c != hc) stable = 1'b0;
        end
        chk("t6_hold", 32'(stable), 1);
        chk("t6_no_xfer", n_xfer - base_x, 0);
        bus.fp_ready = 1'b1;
        wait_done("t6", 50);
        chk("t6_one_xfer", n_xfer - base_x, 1);

        // reset during READ, then rerun with the same seed
        base_a = addr_q.size();
        go(32'hC0FF_EE11, 11'd1024, 16'd2);
        k = 0;
        while (!bus.mem_rd && k < 50) begin tick(1); k++; end
        tick(1);
        reset = 1'b0;
        #1;
        chk("t7_busy0", 32'(busy), 0);
        chk("t7_mem_rd0", 32'(bus.mem_rd), 0);
        chk("t7_addr0", 32'(bus.mem_addr), 0);
        chk("t7_fpv0", 32'(bus.fp_valid), 0);
        chk("t7_fpa0", 32'(bus.fp_a), 0);
        chk("t7_seq0", 32'(bus.plane_seq), 0);
        chk("t7_out_valid0", 32'(bus.plane_out_valid), 0);
        s = 32'hC0FF_EE11;
        sw_pick(s, 1024, ea, eb, ec);
        chk("t7_partial_cnt", addr_q.size() - base_a, 1);
        chk("t7_partial_a", 32'(addr_q[base_a]), ea);
        base_d = err_q.size();
        tick(2);
        chk("t7_no_done", err_q.size() - base_d, 0);
        reset = 1'b1;
        tick(1);
        base_a = addr_q.size();
        go(32'hC0FF_EE11, 11'd1024, 16'd1);
        wait_done("t7", 60);
        chk("t7_rerun_a", 32'(addr_q[base_a]), ea);
        chk("t7_rerun_b", 32'(addr_q[base_a+1]), eb);
        chk("t7_rerun_c", 32'(addr_q[base_a+2]), ec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
